ddr_channel_arb_rr: RTL and testbench



---
 rtl/ddr_channel_arb_rr.sv | 171 +++++++++++++++++
 tb/tb_ddr_channel_arb_rr.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_channel_arb_rr.sv
// ddr_channel_arb_rr: multiplexes NUM_CH request channels onto a single-outstanding DDR port
// using round-robin or fixed-priority arbitration. Revision 1.0.
`default_nettype none

module ddr_channel_arb_rr #(
    parameter int                 NUM_CH     = 3,
    parameter int                 INDEX_W    = 19,
    parameter int                 DATA_W     = 64,
    parameter int                 BURST_W    = 512,
    parameter logic [NUM_CH-1:0]  BURST_CH   = NUM_CH'(3'b001),
    parameter bit                 FIXED_PRIO = 1'b0
) (
    input  logic                       i_clock,
    input  logic                       i_reset_n,

    input  logic [NUM_CH-1:0]          i_ch_valid,
    output logic [NUM_CH-1:0]          o_ch_ready,
    input  logic [NUM_CH*INDEX_W-1:0]  i_ch_index,
    input  logic [NUM_CH-1:0]          i_ch_write,
    input  logic [NUM_CH*DATA_W-1:0]   i_ch_wmask,
    input  logic [NUM_CH*DATA_W-1:0]   i_ch_wdata,
    output logic [NUM_CH-1:0]          o_ch_done,
    output logic [DATA_W-1:0]          o_ch_rdata,
    output logic [BURST_W-1:0]         o_ch_burst_rdata,

    output logic                       o_ddr_chip_enable,
    output logic [INDEX_W-1:0]         o_ddr_index,
    output logic                       o_ddr_write_enable,
    output logic                       o_ddr_burst_mode,
    output logic [DATA_W-1:0]          o_ddr_write_mask,
    output logic [DATA_W-1:0]          o_ddr_write_data,
    input  logic [DATA_W-1:0]          i_ddr_read_data,
    input  logic [BURST_W-1:0]         i_ddr_burst_read_data,
    input  logic                       i_ddr_operation_done,
    input  logic                       i_ddr_ready
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               r_state;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic [PTR_W-1:0]     r_owner;
    logic [INDEX_W-1:0]   r_index;
    logic                 r_write;
    logic                 r_burst;
    logic [DATA_W-1:0]    r_mask;
    logic [DATA_W-1:0]    r_data;
    logic                 r_ce;
    logic [NUM_CH-1:0]    r_done;
    logic [DATA_W-1:0]    r_rdata;
    logic [BURST_W-1:0]   r_burst_rdata;

    logic [PTR_W-1:0]     w_base;
    logic [PTR_W-1:0]     w_winner;
    logic                 w_found;
    logic                 w_accept;
    logic [NUM_CH-1:0]    w_ready;
    logic [NUM_CH-1:0]    w_owner_oh;
    logic                 w_win_burst;

    function automatic logic [PTR_W-1:0] f_wrap(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CH) s = s - NUM_CH;
        return PTR_W'(s);
    endfunction

    // Fixed priority is a search that always starts at channel 0.
    assign w_base = FIXED_PRIO ? '0 : r_rr_ptr;

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!w_found && i_ch_valid[f_wrap(w_base, i)]) begin
                w_found  = 1'b1;
                w_winner = f_wrap(w_base, i);
            end
        end
    end

    assign w_accept    = (r_state == S_IDLE) && i_ddr_ready && w_found;
    assign w_win_burst = BURST_CH[w_winner];

    always_comb begin
        w_ready    = '0;
        w_owner_oh = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_ready[i]    = w_accept && (w_winner == PTR_W'(i));
            w_owner_oh[i] = (r_owner == PTR_W'(i));
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_owner       <= '0;
            r_index       <= '0;
            r_write       <= 1'b0;
            r_burst       <= 1'b0;
            r_mask        <= '0;
            r_data        <= '0;
            r_ce          <= 1'b0;
            r_done        <= '0;
            r_rdata       <= '0;
            r_burst_rdata <= '0;
        end else begin
            r_ce   <= 1'b0;
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_winner;
                        r_index <= i_ch_index[w_winner*INDEX_W +: INDEX_W];
                        r_mask  <= i_ch_wmask[w_winner*DATA_W +: DATA_W];
                        r_data  <= i_ch_wdata[w_winner*DATA_W +: DATA_W];
                        r_burst <= w_win_burst;
                        // Burst channels are read-only on the DDR side.
                        r_write <= i_ch_write[w_winner] & ~w_win_burst;
                        r_ce    <= 1'b1;
                        r_state <= S_ISSUE;
                        if (!FIXED_PRIO) begin
                            r_rr_ptr <= (w_winner == PTR_W'(NUM_CH - 1)) ? '0 : w_winner + 1'b1;
                        end
                    end
                end
                S_ISSUE, S_WAIT: begin
                    if (i_ddr_operation_done) begin
                        if (r_burst) begin
                            r_burst_rdata <= i_ddr_burst_read_data;
                        end else if (!r_write) begin
                            r_rdata <= i_ddr_read_data;
                        end
                        r_done  <= w_owner_oh;
                        r_state <= S_RESP;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ch_ready         = w_ready;
    assign o_ch_done          = r_done;
    assign o_ch_rdata         = r_rdata;
    assign o_ch_burst_rdata   = r_burst_rdata;
    assign o_ddr_chip_enable  = r_ce;
    assign o_ddr_index        = r_index;
    assign o_ddr_write_enable = r_write;
    assign o_ddr_burst_mode   = r_burst;
    assign o_ddr_write_mask   = r_mask;
    assign o_ddr_write_data   = r_data;

endmodule

`default_nettype wire

// File: tb/tb_ddr_channel_arb_rr.sv
// Scoreboard bench for ddr_channel_arb_rr: a round-robin instance fully checked,
// plus a fixed-priority instance on the same stimulus checked for grant ownership.
`default_nettype none

module tb_ddr_channel_arb_rr;

    localparam int NCH = 3;
    localparam int IW  = 19;
    localparam int DW  = 64;
    localparam int BW  = 512;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    ch_valid;
    logic [NCH*IW-1:0] ch_index;
    logic [NCH-1:0]    ch_write;
    logic [NCH*DW-1:0] ch_wmask;
    logic [NCH*DW-1:0] ch_wdata;
    logic [DW-1:0]     ddr_rd;
    logic [BW-1:0]     ddr_brd;
    logic              ddr_done;
    logic              ddr_ready;

    logic [NCH-1:0]    rr_ready, rr_done;
    logic [DW-1:0]     rr_rdata;
    logic [BW-1:0]     rr_brdata;
    logic              rr_ce, rr_we, rr_burst;
    logic [IW-1:0]     rr_idx;
    logic [DW-1:0]     rr_mask, rr_data;

    logic [NCH-1:0]    fp_ready, fp_done;
    logic [DW-1:0]     fp_rdata;
    logic [BW-1:0]     fp_brdata;
    logic              fp_ce, fp_we, fp_burst;
    logic [IW-1:0]     fp_idx;
    logic [DW-1:0]     fp_mask, fp_data;

    always #5 clk = ~clk;

    ddr_channel_arb_rr #(.NUM_CH(NCH), .INDEX_W(IW), .DATA_W(DW), .BURST_W(BW),
                         .BURST_CH(3'b001), .FIXED_PRIO(1'b0)) u_rr (
        .i_clock(clk), .i_reset_n(rst_n),
        .i_ch_valid(ch_valid), .o_ch_ready(rr_ready), .i_ch_index(ch_index),
        .i_ch_write(ch_write), .i_ch_wmask(ch_wmask), .i_ch_wdata(ch_wdata),
        .o_ch_done(rr_done), .o_ch_rdata(rr_rdata), .o_ch_burst_rdata(rr_brdata),
        .o_ddr_chip_enable(rr_ce), .o_ddr_index(rr_idx), .o_ddr_write_enable(rr_we),
        .o_ddr_burst_mode(rr_burst), .o_ddr_write_mask(rr_mask), .o_ddr_write_data(rr_data),
        .i_ddr_read_data(ddr_rd), .i_ddr_burst_read_data(ddr_brd),
        .i_ddr_operation_done(ddr_done), .i_ddr_ready(ddr_ready)
    );

    ddr_channel_arb_rr #(.NUM_CH(NCH), .INDEX_W(IW), .DATA_W(DW), .BURST_W(BW),
                         .BURST_CH(3'b001), .FIXED_PRIO(1'b1)) u_fp (
        .i_clock(clk), .i_reset_n(rst_n),
        .i_ch_valid(ch_valid), .o_ch_ready(fp_ready), .i_ch_index(ch_index),
        .i_ch_write(ch_write), .i_ch_wmask(ch_wmask), .i_ch_wdata(ch_wdata),
        .o_ch_done(fp_done), .o_ch_rdata(fp_rdata), .o_ch_burst_rdata(fp_brdata),
        .o_ddr_chip_enable(fp_ce), .o_ddr_index(fp_idx), .o_ddr_write_enable(fp_we),
        .o_ddr_burst_mode(fp_burst), .o_ddr_write_mask(fp_mask), .o_ddr_write_data(fp_data),
        .i_ddr_read_data(ddr_rd), .i_ddr_burst_read_data(ddr_brd),
        .i_ddr_operation_done(ddr_done), .i_ddr_ready(ddr_ready)
    );

    typedef struct {
        int            owner;
        logic [IW-1:0] idx;
        logic          we;
        logic          burst;
        logic [DW-1:0] mask;
        logic [DW-1:0] data;
        int            lat;
        logic [DW-1:0] rdata;
        logic [BW-1:0] brdata;
    } op_t;

    op_t  q_op[$];
    int   q_fp[$];
    op_t  cur;
    bit   have_cur = 1'b0;
    int   t_acc = 0;
    int   fp_owner = 0;
    bit   fp_have = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_done = 0;

    logic [DW-1:0] resp_word  = '0;
    logic [BW-1:0] resp_burst = '0;
    int            resp_lat   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NCH-1:0] oh(input int i);
        return NCH'(1 << i);
    endfunction

    // DDR model: done arrives resp_lat cycles after the issue strobe (0 = same cycle).
    always @(negedge clk) begin
        if (rr_ce) begin
            if (resp_lat > 0) repeat (resp_lat) @(negedge clk);
            ddr_rd   = resp_word;
            ddr_brd  = resp_burst;
            ddr_done = 1'b1;
            @(negedge clk);
            ddr_done = 1'b0;
        end
    end

    // Monitor: pops expectations when the DUTs present grants, issues and completions.
    always @(negedge clk) begin
        if (rr_ready != '0) begin
            chk("ready_only_when_ddr_ready", ddr_ready, 1);
            if (q_op.size() == 0) begin
                chk("unexpected_grant", rr_ready, 0);
            end else begin
                cur      = q_op.pop_front();
                have_cur = 1'b1;
                t_acc    = cyc;
                chk("grant", rr_ready, oh(cur.owner));
            end
        end
        if (!ddr_ready) chk("no_ready_while_ddr_busy", rr_ready, 0);
        if (rr_ce) begin
            if (!have_cur) begin
                chk("unexpected_issue", rr_ce, 0);
            end else begin
                chk("issue_latency", cyc, t_acc + 1);
                chk("issue_index", rr_idx, cur.idx);
                chk("issue_write_en", rr_we, cur.we);
                chk("issue_burst", rr_burst, cur.burst);
                chk("issue_mask", rr_mask, cur.mask);
                chk("issue_data", rr_data, cur.data);
            end
        end
        if (rr_done != '0) begin
            if (!have_cur) begin
                chk("unexpected_done", rr_done, 0);
            end else begin
                chk("done_owner", rr_done, oh(cur.owner));
                chk("done_latency", cyc, t_acc + 2 + cur.lat);
                chk("rdata", rr_rdata, cur.rdata);
                chk("burst_rdata", rr_brdata, cur.brdata);
                chk("ddr_outs_stable_in_resp", {rr_idx, rr_we, rr_burst}, {cur.idx, cur.we, cur.burst});
                have_cur = 1'b0;
            end
            n_done++;
        end
        if (fp_ready != '0) begin
            if (q_fp.size() == 0) begin
                chk("fp_unexpected_grant", fp_ready, 0);
            end else begin
                fp_owner = q_fp.pop_front();
                fp_have  = 1'b1;
                chk("fp_grant", fp_ready, oh(fp_owner));
            end
        end
        if (fp_done != '0) begin
            if (!fp_have) chk("fp_unexpected_done", fp_done, 0);
            else chk("fp_done_owner", fp_done, oh(fp_owner));
            fp_have = 1'b0;
        end
    end

    task automatic push_op(input int owner, input logic [IW-1:0] idx, input logic we,
                           input logic burst, input logic [DW-1:0] mask, input logic [DW-1:0] data,
                           input int lat, input logic [DW-1:0] rdata, input logic [BW-1:0] brdata);
        op_t o;
        o.owner = owner; o.idx = idx; o.we = we; o.burst = burst; o.mask = mask;
        o.data = data; o.lat = lat; o.rdata = rdata; o.brdata = brdata;
        q_op.push_back(o);
    endtask

    task automatic drive(input int ch, input logic [IW-1:0] idx, input logic wr,
                         input logic [DW-1:0] mask, input logic [DW-1:0] data);
        ch_index[ch*IW +: IW] = idx;
        ch_write[ch]          = wr;
        ch_wmask[ch*DW +: DW] = mask;
        ch_wdata[ch*DW +: DW] = data;
        ch_valid[ch]          = 1'b1;
    endtask

    task automatic wait_accept(input int ch);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rr_ready[ch]) begin
                @(posedge clk); #1;
                ch_valid[ch] = 1'b0;
                return;
            end
        end
        chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_done(input int target);
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (n_done >= target) return;
        end
        chk("done_timeout", n_done, target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ch_valid = '0; ch_index = '0; ch_write = '0; ch_wmask = '0; ch_wdata = '0;
        ddr_rd = '0; ddr_brd = '0; ddr_done = 1'b0; ddr_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", rr_ready, 0);
        chk("rst_done", rr_done, 0);
        chk("rst_ce", rr_ce, 0);
        chk("rst_index", rr_idx, 0);
        chk("rst_we_burst", {rr_we, rr_burst}, 0);
        chk("rst_mask_data", {rr_mask, rr_data}, 0);
        chk("rst_rdata", rr_rdata, 0);
        chk("rst_burst_rdata", rr_brdata, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Word read on ch1, done three cycles after the issue strobe.
        resp_word = 64'h1111_2222_3333_4444; resp_lat = 3;
        push_op(1, 19'h1234, 1'b0, 1'b0, '0, '0, 3, 64'h1111_2222_3333_4444, '0);
        q_fp.push_back(1);
        drive(1, 19'h1234, 1'b0, '0, '0);
        wait_accept(1);
        wait_done(1);

        // Burst fetch on ch0: word read data must not move.
        resp_burst = {64{8'hA5}}; resp_word = 64'h0BAD_0BAD_0BAD_0BAD; resp_lat = 2;
        push_op(0, 19'h40, 1'b0, 1'b1, '0, '0, 2, 64'h1111_2222_3333_4444, {64{8'hA5}});
        q_fp.push_back(0);
        drive(0, 19'h40, 1'b0, '0, '0);
        wait_accept(0);
        wait_done(2);

        // Write attempt on burst channel 0 becomes a burst read; done arrives in ISSUE.
        resp_burst = {64{8'h5A}}; resp_lat = 0;
        push_op(0, 19'h41, 1'b0, 1'b1, '1, 64'h0123_4567_89AB_CDEF, 0,
                64'h1111_2222_3333_4444, {64{8'h5A}});
        q_fp.push_back(0);
        drive(0, 19'h41, 1'b1, '1, 64'h0123_4567_89AB_CDEF);
        wait_accept(0);
        wait_done(3);
        ch_write[0] = 1'b0;

        // ch2 store held off by ddr_ready=0 for four cycles.
        resp_word = 64'hCAFE_CAFE_CAFE_CAFE; resp_lat = 1;
        push_op(2, 19'h7_0002, 1'b1, 1'b0, 64'hFF, 64'hDEAD_BEEF, 1,
                64'h1111_2222_3333_4444, {64{8'h5A}});
        q_fp.push_back(2);
        ddr_ready = 1'b0;
        drive(2, 19'h7_0002, 1'b1, 64'hFF, 64'hDEAD_BEEF);
        repeat (4) @(posedge clk);
        #1;
        ddr_ready = 1'b1;
        @(negedge clk);
        chk("accept_on_first_ddr_ready", rr_ready, 3'b100);
        @(posedge clk); #1;
        ch_valid[2] = 1'b0;
        ch_write[2] = 1'b0;
        wait_done(4);

        // All three channels held valid for six grants.
        resp_word = 64'h5555_AAAA_5555_AAAA; resp_burst = {64{8'h3C}}; resp_lat = 1;
        push_op(0, 19'h100, 1'b0, 1'b1, '0, '0, 1, 64'h1111_2222_3333_4444, {64{8'h3C}});
        push_op(1, 19'h101, 1'b0, 1'b0, '0, '0, 1, 64'h5555_AAAA_5555_AAAA, {64{8'h3C}});
        push_op(2, 19'h102, 1'b0, 1'b0, '0, '0, 1, 64'h5555_AAAA_5555_AAAA, {64{8'h3C}});
        push_op(0, 19'h100, 1'b0, 1'b1, '0, '0, 1, 64'h5555_AAAA_5555_AAAA, {64{8'h3C}});
        push_op(1, 19'h101, 1'b0, 1'b0, '0, '0, 1, 64'h5555_AAAA_5555_AAAA, {64{8'h3C}});
        push_op(2, 19'h102, 1'b0, 1'b0, '0, '0, 1, 64'h5555_AAAA_5555_AAAA, {64{8'h3C}});
        for (int k = 0; k < 6; k++) q_fp.push_back(0);
        drive(0, 19'h100, 1'b0, '0, '0);
        drive(1, 19'h101, 1'b0, '0, '0);
        drive(2, 19'h102, 1'b0, '0, '0);
        wait_done(10);
        ch_valid = '0;

        // Reset during WAIT aborts the op; the late done pulse must be ignored.
        resp_word = 64'h9999_9999_9999_9999; resp_lat = 8;
        push_op(1, 19'h200, 1'b0, 1'b0, '0, '0, 8, '0, '0);
        q_fp.push_back(1);
        drive(1, 19'h200, 1'b0, '0, '0);
        wait_accept(1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        have_cur = 1'b0;
        fp_have  = 1'b0;
        chk("abort_ce", rr_ce, 0);
        chk("abort_ddr_outs", {rr_idx, rr_we, rr_burst, rr_mask, rr_data}, 0);
        chk("abort_done", rr_done, 0);
        chk("abort_rdata", rr_rdata, 0);
        chk("abort_burst_rdata", rr_brdata, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("no_done_after_abort", n_done, 10);

        // ch1 and ch2 both valid: rr_ptr back at 0 means ch1 wins.
        resp_word = 64'h7777_0000_7777_0000; resp_lat = 2;
        push_op(1, 19'h301, 1'b0, 1'b0, '0, '0, 2, 64'h7777_0000_7777_0000, '0);
        q_fp.push_back(1);
        drive(1, 19'h301, 1'b0, '0, '0);
        drive(2, 19'h302, 1'b0, '0, '0);
        wait_done(11);
        ch_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", q_op.size(), 0);
        chk("fp_scoreboard_drained", q_fp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
